// File: rtl/conv_pkg.sv
// Shared constants, state encoding and helpers for the convolution layer scheduler.
package conv_pkg;

    localparam int IMG_W     = 28;
    localparam int KSIZE     = 5;
    localparam int OUT_W     = IMG_W - KSIZE + 1;
    localparam int NUM_KER   = 6;
    localparam int PIX_BITS  = 16;
    localparam int RES_BITS  = 32;
    localparam int FLUSH_MAX = 256;

    localparam int NPIX    = IMG_W * IMG_W;
    localparam int NRES    = OUT_W * OUT_W;
    localparam int IMG_AW  = $clog2(NPIX);
    localparam int OUT_AW  = $clog2(NUM_KER * NRES);
    localparam int KW      = $clog2(NUM_KER) + 1;
    localparam int FLUSH_W = $clog2(FLUSH_MAX + 1);
    localparam int RES_CW  = $clog2(NRES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_FLUSH,
        ST_NEXT,
        ST_DONE
    } sched_state_t;

    // Requests for more kernels than the engine holds run all of them.
    function automatic logic [KW-1:0] clamp_ker(input logic [KW-1:0] n);
        return (n > KW'(NUM_KER)) ? KW'(NUM_KER) : n;
    endfunction

endpackage

// File: rtl/conv_res_writer.sv
// Captures engine results into the output feature memory; keeps the per-kernel
// result count and the running base address of the current kernel's plane.
module conv_res_writer
    import conv_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                cap_en,
    input  logic                cnt_clr,
    input  logic                base_clr,
    input  logic                base_add,
    input  logic [RES_BITS-1:0] eng_res,
    input  logic                eng_res_valid,
    output logic                res_full,
    output logic                out_wr_en,
    output logic [OUT_AW-1:0]   out_wr_addr,
    output logic [RES_BITS-1:0] out_wr_data
);

    logic [RES_CW-1:0]   res_cnt;
    logic [OUT_AW-1:0]   base;
    logic                wr_en_q;
    logic [OUT_AW-1:0]   wr_addr_q;
    logic [RES_BITS-1:0] wr_data_q;

    assign res_full    = (res_cnt == RES_CW'(NRES));
    // A write registered just before a reset must not reach memory during the reset cycle.
    assign out_wr_en   = wr_en_q & ~reset;
    assign out_wr_addr = wr_addr_q;
    assign out_wr_data = wr_data_q;

    // Register one result per strobe until the kernel's plane is full; base steps by a plane per kernel.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_cnt   <= '0;
            base      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (cnt_clr) begin
                res_cnt <= '0;
            end else if (cap_en && eng_res_valid && !res_full) begin
                wr_en_q   <= 1'b1;
                wr_data_q <= eng_res;
                wr_addr_q <= base + OUT_AW'(res_cnt);
                res_cnt   <= res_cnt + RES_CW'(1);
            end
            if (base_clr) begin
                base <= '0;
            end else if (base_add) begin
                base <= base + OUT_AW'(NRES);
            end
        end
    end

endmodule

// File: rtl/conv_layer_sched.sv
// Sequences the shared convolution engine over each kernel of a layer:
// clear, stream the frame, pad until all results are written, advance.
//
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | one-cycle engine clear, per-kernel counters reset
// STREAM | reading the frame, one pixel per cycle
// FLUSH  | feeding zero pixels until the result plane is full or the flush timer expires
// NEXT   | advance base and kernel index, or finish
// DONE   | one-cycle completion pulse
module conv_layer_sched
    import conv_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [KW-1:0]       cfg_num_ker,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                img_rd_en,
    output logic [IMG_AW-1:0]   img_rd_addr,
    input  logic [PIX_BITS-1:0] img_rd_data,
    output logic                eng_clr,
    output logic [KW-1:0]       eng_ker_sel,
    output logic [PIX_BITS-1:0] eng_pix,
    output logic                eng_pix_valid,
    input  logic [RES_BITS-1:0] eng_res,
    input  logic                eng_res_valid,
    output logic                out_wr_en,
    output logic [OUT_AW-1:0]   out_wr_addr,
    output logic [RES_BITS-1:0] out_wr_data
);

    sched_state_t        state, nxt;
    logic [IMG_AW-1:0]   rd_addr;
    logic [FLUSH_W-1:0]  flush_cnt;
    logic [KW-1:0]       ker_idx;
    logic [KW-1:0]       cfg_q;
    logic                err_q;
    logic                rd_q;
    logic                res_full;

    logic start_acc;
    logic clr_c;
    logic rd_en_c;
    logic cap_en_c;
    logic base_add_c;
    logic set_err_c;
    logic done_c;
    logic busy_c;

    // Next-state and per-state strobes.
    always_comb begin
        nxt        = state;
        start_acc  = 1'b0;
        clr_c      = 1'b0;
        rd_en_c    = 1'b0;
        cap_en_c   = 1'b0;
        base_add_c = 1'b0;
        set_err_c  = 1'b0;
        done_c     = 1'b0;
        busy_c     = 1'b1;
        case (state)
            ST_IDLE: begin
                busy_c = 1'b0;
                if (start) begin
                    start_acc = 1'b1;
                    nxt = (clamp_ker(cfg_num_ker) == '0) ? ST_DONE : ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clr_c = 1'b1;
                nxt   = ST_STREAM;
            end
            ST_STREAM: begin
                rd_en_c  = 1'b1;
                cap_en_c = 1'b1;
                if (rd_addr == IMG_AW'(NPIX - 1)) begin
                    nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                cap_en_c = 1'b1;
                if (res_full) begin
                    nxt = ST_NEXT;
                end else if (flush_cnt == FLUSH_W'(FLUSH_MAX - 1)) begin
                    set_err_c = 1'b1;
                    nxt       = ST_DONE;
                end
            end
            ST_NEXT: begin
                base_add_c = 1'b1;
                nxt = ((ker_idx + KW'(1)) == cfg_q) ? ST_DONE : ST_CLEAR;
            end
            ST_DONE: begin
                busy_c = 1'b0;
                done_c = 1'b1;
                nxt    = ST_IDLE;
            end
            default: begin
                busy_c = 1'b0;
                nxt    = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Read address, flush timer, kernel bookkeeping and the error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr   <= '0;
            flush_cnt <= '0;
            ker_idx   <= '0;
            cfg_q     <= '0;
            err_q     <= 1'b0;
            rd_q      <= 1'b0;
        end else begin
            rd_q <= rd_en_c;
            if (start_acc) begin
                cfg_q   <= clamp_ker(cfg_num_ker);
                ker_idx <= '0;
                err_q   <= 1'b0;
            end
            if (base_add_c && nxt == ST_CLEAR) begin
                ker_idx <= ker_idx + KW'(1);
            end
            if (set_err_c) begin
                err_q <= 1'b1;
            end
            if (clr_c) begin
                rd_addr   <= '0;
                flush_cnt <= '0;
            end else begin
                if (rd_en_c) begin
                    rd_addr <= rd_addr + IMG_AW'(1);
                end
                if (state == ST_FLUSH) begin
                    flush_cnt <= flush_cnt + FLUSH_W'(1);
                end
            end
        end
    end

    // Memory data already arrives one cycle after the read, so only the valid needs delaying.
    assign eng_pix       = rd_q ? img_rd_data : '0;
    assign eng_pix_valid = rd_q | (state == ST_FLUSH);
    assign img_rd_en     = rd_en_c;
    assign img_rd_addr   = rd_addr;
    assign eng_clr       = clr_c;
    assign eng_ker_sel   = ker_idx;
    assign busy          = busy_c;
    assign done          = done_c & ~reset;
    assign err           = err_q;

    conv_res_writer u_writer (
        .clk           (clk),
        .reset         (reset),
        .cap_en        (cap_en_c),
        .cnt_clr       (clr_c),
        .base_clr      (start_acc),
        .base_add      (base_add_c),
        .eng_res       (eng_res),
        .eng_res_valid (eng_res_valid),
        .res_full      (res_full),
        .out_wr_en     (out_wr_en),
        .out_wr_addr   (out_wr_addr),
        .out_wr_data   (out_wr_data)
    );

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed bench for conv_layer_sched with a frame-memory model and a
// behavioural engine that emits one result per valid 5x5 window position.
module tb_conv_layer_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  cfg_num_ker = '0;
    logic        busy, done, err;
    logic        img_rd_en;
    logic [9:0]  img_rd_addr;
    logic [15:0] img_rd_data = '0;
    logic        eng_clr;
    logic [3:0]  eng_ker_sel;
    logic [15:0] eng_pix;
    logic        eng_pix_valid;
    logic [31:0] eng_res = '0;
    logic        eng_res_valid = 1'b0;
    logic        out_wr_en;
    logic [11:0] out_wr_addr;
    logic [31:0] out_wr_data;

    conv_layer_sched dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .cfg_num_ker   (cfg_num_ker),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .img_rd_en     (img_rd_en),
        .img_rd_addr   (img_rd_addr),
        .img_rd_data   (img_rd_data),
        .eng_clr       (eng_clr),
        .eng_ker_sel   (eng_ker_sel),
        .eng_pix       (eng_pix),
        .eng_pix_valid (eng_pix_valid),
        .eng_res       (eng_res),
        .eng_res_valid (eng_res_valid),
        .out_wr_en     (out_wr_en),
        .out_wr_addr   (out_wr_addr),
        .out_wr_data   (out_wr_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic stat_clr   = 1'b0;
    logic busy_track = 1'b0;
    logic extra_en   = 1'b0;
    int   res_limit  = 576;

    function automatic logic [15:0] pixf(input int a);
        return 16'(a) ^ 16'h5A00;
    endfunction

    function automatic logic [31:0] exp_wr(input int n);
        int j, k, a;
        j = n / 576;
        k = n % 576;
        a = (4 + k / 24) * 28 + 4 + k % 24;
        return {12'b0, 4'(j), pixf(a)};
    endfunction

    // Frame memory: one-cycle read latency.
    always @(posedge clk) begin
        if (img_rd_en) img_rd_data <= pixf(int'(img_rd_addr));
    end

    // Engine: one result per pixel that completes a 5x5 window, optional stray result after the plane.
    int pix_n = 0;
    int res_n = 0;
    always @(posedge clk) begin
        if (reset || eng_clr) begin
            pix_n <= 0;
            res_n <= 0;
            eng_res_valid <= 1'b0;
        end else begin
            eng_res_valid <= 1'b0;
            if (eng_pix_valid) begin
                pix_n <= pix_n + 1;
                if (pix_n < 784 && pix_n / 28 >= 4 && pix_n % 28 >= 4 && res_n < res_limit) begin
                    eng_res_valid <= 1'b1;
                    eng_res <= {12'b0, eng_ker_sel, eng_pix};
                    res_n <= res_n + 1;
                end else if (extra_en && pix_n >= 784 && res_n == 576) begin
                    eng_res_valid <= 1'b1;
                    eng_res <= 32'hDEAD_BEEF;
                    res_n <= res_n + 1;
                end
            end
        end
    end

    // Activity monitor: tallies and sequence mismatches, reviewed by the main sequence.
    int rd_n, rd_bad, clr_n, sel_bad, pv_n, pix_bad, wr_n, wr_addr_bad, wr_data_bad;
    int last_wr_addr, last_wr_cyc, done_n, done_cyc, busy_gap, cyc;
    always @(negedge clk) begin
        if (stat_clr) begin
            rd_n = 0; rd_bad = 0; clr_n = 0; sel_bad = 0; pv_n = 0; pix_bad = 0;
            wr_n = 0; wr_addr_bad = 0; wr_data_bad = 0; last_wr_addr = -1;
            last_wr_cyc = 0; done_n = 0; done_cyc = 0; busy_gap = 0; cyc = 0;
        end else begin
            if (img_rd_en) begin
                if (int'(img_rd_addr) != rd_n % 784) rd_bad++;
                rd_n++;
            end
            if (eng_clr) begin
                if (int'(eng_ker_sel) != clr_n) sel_bad++;
                clr_n++;
            end
            if (eng_pix_valid) begin
                if (eng_pix !== ((pix_n < 784) ? pixf(pix_n) : 16'h0)) pix_bad++;
                pv_n++;
            end
            if (out_wr_en) begin
                if (int'(out_wr_addr) != wr_n) wr_addr_bad++;
                if (out_wr_data !== exp_wr(wr_n)) wr_data_bad++;
                last_wr_addr = int'(out_wr_addr);
                last_wr_cyc = cyc;
                wr_n++;
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (busy_track && !done && !busy) busy_gap++;
            cyc++;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        @(negedge clk); stat_clr = 1'b1;
        @(negedge clk);
        @(negedge clk); stat_clr = 1'b0;
    endtask

    task automatic start_layer(input int cfg);
        @(negedge clk);
        cfg_num_ker = 4'(cfg);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_track = 1'b1;
    endtask

    task automatic wait_done(input int limit, output int lat, output int err_at_done);
        int got;
        got = 0;
        lat = 0;
        err_at_done = -1;
        while (!got && lat < limit) begin
            @(negedge clk);
            lat++;
            if (done) begin
                got = 1;
                err_at_done = int'(err);
            end
        end
        busy_track = 1'b0;
        chk("done_seen", got, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_mon(input string t);
        chk({t, "_rd_seq"}, rd_bad, 0);
        chk({t, "_ker_sel"}, sel_bad, 0);
        chk({t, "_pix"}, pix_bad, 0);
        chk({t, "_wr_addr"}, wr_addr_bad, 0);
        chk({t, "_wr_data"}, wr_data_bad, 0);
        chk({t, "_busy_gap"}, busy_gap, 0);
    endtask

    initial begin
        int lat, e, snap, n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_rd_en", int'(img_rd_en), 0);
        chk("rst_rd_addr", int'(img_rd_addr), 0);
        chk("rst_clr", int'(eng_clr), 0);
        chk("rst_pix_valid", int'(eng_pix_valid), 0);
        chk("rst_wr_en", int'(out_wr_en), 0);
        chk("rst_ker_sel", int'(eng_ker_sel), 0);
        @(negedge clk); reset = 1'b0;

        // 1: single kernel
        clear_stats();
        start_layer(1);
        wait_done(5000, lat, e);
        chk("t1_latency", lat, 790);
        chk("t1_reads", rd_n, 784);
        chk("t1_writes", wr_n, 576);
        chk("t1_last_addr", last_wr_addr, 575);
        chk("t1_clr", clr_n, 1);
        chk("t1_done", done_n, 1);
        chk("t1_err", e, 0);
        chk("t1_pix_valids", pv_n, 786);
        check_mon("t1");

        // 2: six kernels
        clear_stats();
        start_layer(6);
        wait_done(8000, lat, e);
        chk("t2_reads", rd_n, 6 * 784);
        chk("t2_writes", wr_n, 3456);
        chk("t2_last_addr", last_wr_addr, 3455);
        chk("t2_clr", clr_n, 6);
        chk("t2_done", done_n, 1);
        chk("t2_done_after_wr", int'(done_cyc > last_wr_cyc), 1);
        chk("t2_err", e, 0);
        check_mon("t2");

        // 3: zero kernels
        clear_stats();
        start_layer(0);
        wait_done(20, lat, e);
        chk("t3_latency", lat, 1);
        chk("t3_reads", rd_n, 0);
        chk("t3_clr", clr_n, 0);
        chk("t3_writes", wr_n, 0);
        chk("t3_done", done_n, 1);

        // 4: engine stalls at 500 results -> flush timeout
        res_limit = 500;
        clear_stats();
        start_layer(2);
        wait_done(3000, lat, e);
        chk("t4_err", e, 1);
        chk("t4_writes", wr_n, 500);
        chk("t4_clr", clr_n, 1);
        chk("t4_pix_valids", pv_n, 783 + 256);
        chk("t4_done", done_n, 1);
        check_mon("t4");
        res_limit = 576;

        // 5: reset mid-stream at read address 300
        clear_stats();
        start_layer(1);
        chk("t5_err_cleared", int'(err), 0);
        n = 0;
        while (!(img_rd_en && img_rd_addr == 10'd300) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reached_300", int'(img_rd_addr), 300);
        reset = 1'b1;
        busy_track = 1'b0;
        #1;
        chk("t5_wr_in_rst", int'(out_wr_en), 0);
        chk("t5_done_in_rst", int'(done), 0);
        snap = wr_n;
        @(posedge clk); #1;
        chk("t5_busy", int'(busy), 0);
        chk("t5_rd_en", int'(img_rd_en), 0);
        chk("t5_pix_valid", int'(eng_pix_valid), 0);
        chk("t5_ker_sel", int'(eng_ker_sel), 0);
        @(negedge clk); reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("t5_no_more_wr", wr_n, snap);
        chk("t5_no_done", done_n, 0);
        clear_stats();
        start_layer(1);
        wait_done(5000, lat, e);
        chk("t5r_reads", rd_n, 784);
        chk("t5r_writes", wr_n, 576);
        chk("t5r_done", done_n, 1);
        check_mon("t5r");

        // 6: start while busy, plus a stray 577th result
        extra_en = 1'b1;
        clear_stats();
        start_layer(1);
        n = 0;
        while (!(img_rd_en && img_rd_addr == 10'd400) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        cfg_num_ker = 4'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_num_ker = 4'd1;
        wait_done(5000, lat, e);
        chk("t6_extra_sent", res_n, 577);
        chk("t6_writes", wr_n, 576);
        chk("t6_reads", rd_n, 784);
        chk("t6_clr", clr_n, 1);
        chk("t6_done", done_n, 1);
        check_mon("t6");
        extra_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
